// File: rtl/dijkstra_pkg.sv
// Shared types and constants for the shortest-path engine blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dijkstra_pkg;

    // Default widths used by blocks that are not explicitly parameterised.
    localparam int DEFAULT_MAX_NODES   = 64;
    localparam int DEFAULT_INDEX_WIDTH = 8;
    localparam int DEFAULT_MADDR_WIDTH = 16;
    localparam int DEFAULT_MDATA_WIDTH = 32;

    // Predecessor sentinel: all ones at the index width ("no predecessor").
    localparam logic [DEFAULT_INDEX_WIDTH-1:0] NO_PREVIOUS_NODE = '1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WRITE_NODE = 3'd1,
        STEP       = 3'd2,
        WRITE_LEN  = 3'd3,
        DONE       = 3'd4
    } path_writer_state_t;

endpackage

// File: rtl/path_writer.sv
// Walks the predecessor table from destination to source, writing each node then the path length.
// Latency: 2L cycles of FSM activity for an L-node path; done is high in cycle 2L+1 after start.
// Backpressure: write request (enable/addr/data) is registered and held until mem_write_ready is seen high.
module path_writer
    import dijkstra_pkg::*;
#(
    parameter int MAX_NODES   = DEFAULT_MAX_NODES,
    parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
    parameter int MADDR_WIDTH = DEFAULT_MADDR_WIDTH,
    parameter int MDATA_WIDTH = DEFAULT_MDATA_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [INDEX_WIDTH-1:0] source,
    input  logic [INDEX_WIDTH-1:0] destination,
    input  logic [INDEX_WIDTH-1:0] number_of_nodes,
    input  logic [MADDR_WIDTH-1:0] out_base_address,
    output logic [INDEX_WIDTH-1:0] prev_index,
    input  logic [INDEX_WIDTH-1:0] prev_value,
    output logic                   mem_write_enable,
    output logic [MADDR_WIDTH-1:0] mem_addr,
    output logic [MDATA_WIDTH-1:0] mem_write_data,
    input  logic                   mem_write_ready,
    output logic                   done,
    output logic                   no_path
);

    // Elaboration-time sanity checks on the parameter set.
    if (MDATA_WIDTH < INDEX_WIDTH) begin : g_bad_data_width
        $error("path_writer: MDATA_WIDTH must be >= INDEX_WIDTH");
    end
    if (MAX_NODES > (1 << INDEX_WIDTH)) begin : g_bad_max_nodes
        $error("path_writer: MAX_NODES does not fit the index space");
    end

    localparam logic [INDEX_WIDTH-1:0] NO_PREV = {INDEX_WIDTH{1'b1}};

    // One extra bit so a path of the full table depth does not overflow.
    path_writer_state_t     state, state_nxt;
    logic [INDEX_WIDTH-1:0] cur, cur_nxt;
    logic [INDEX_WIDTH:0]   count, count_nxt;
    logic [INDEX_WIDTH-1:0] src_q, src_nxt;
    logic [INDEX_WIDTH-1:0] nn_q, nn_nxt;
    logic [MADDR_WIDTH-1:0] base_q, base_nxt;
    logic                   done_nxt, no_path_nxt;
    logic                   we_nxt;
    logic [MADDR_WIDTH-1:0] addr_nxt;
    logic [MDATA_WIDTH-1:0] data_nxt;

    assign prev_index = cur;

    // Next-state, datapath and next memory-request computation.
    always_comb begin
        state_nxt   = state;
        cur_nxt     = cur;
        count_nxt   = count;
        src_nxt     = src_q;
        nn_nxt      = nn_q;
        base_nxt    = base_q;
        done_nxt    = done;
        no_path_nxt = no_path;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    src_nxt     = source;
                    nn_nxt      = number_of_nodes;
                    base_nxt    = out_base_address;
                    cur_nxt     = destination;
                    count_nxt   = '0;
                    no_path_nxt = 1'b0;
                    done_nxt    = 1'b0;
                    state_nxt   = WRITE_NODE;
                end
            end
            WRITE_NODE: begin
                if (mem_write_ready) begin
                    count_nxt = count + 1'b1;
                    state_nxt = (cur == src_q) ? WRITE_LEN : STEP;
                end
            end
            STEP: begin
                // Missing predecessor or too many hops (cyclic table) both end the walk.
                if ((prev_value == NO_PREV) || (count >= {1'b0, nn_q})) begin
                    no_path_nxt = 1'b1;
                    state_nxt   = WRITE_LEN;
                end else begin
                    cur_nxt   = prev_value;
                    state_nxt = WRITE_NODE;
                end
            end
            WRITE_LEN: begin
                if (mem_write_ready) begin
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // The request is derived from the next state so that it is registered,
        // keeping mem_write_ready off any combinational path to the outputs.
        we_nxt   = 1'b0;
        addr_nxt = mem_addr;
        data_nxt = mem_write_data;
        case (state_nxt)
            WRITE_NODE: begin
                we_nxt   = 1'b1;
                addr_nxt = base_nxt + MADDR_WIDTH'(1) + MADDR_WIDTH'(count_nxt);
                data_nxt = MDATA_WIDTH'(cur_nxt);
            end
            WRITE_LEN: begin
                we_nxt   = 1'b1;
                addr_nxt = base_nxt;
                data_nxt = no_path_nxt ? '0 : MDATA_WIDTH'(count_nxt);
            end
            default: ;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            cur              <= '0;
            count            <= '0;
            src_q            <= '0;
            nn_q             <= '0;
            base_q           <= '0;
            done             <= 1'b0;
            no_path          <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_addr         <= '0;
            mem_write_data   <= '0;
        end else begin
            state            <= state_nxt;
            cur              <= cur_nxt;
            count            <= count_nxt;
            src_q            <= src_nxt;
            nn_q             <= nn_nxt;
            base_q           <= base_nxt;
            done             <= done_nxt;
            no_path          <= no_path_nxt;
            mem_write_enable <= we_nxt;
            mem_addr         <= addr_nxt;
            mem_write_data   <= data_nxt;
        end
    end

endmodule

// File: tb/tb_path_writer.sv
// Directed self-checking bench for path_writer with a logging memory model.
// Latency: checks done timing against hand-computed cycle counts.
// Backpressure: exercises a held write with mem_write_ready low.
module tb_path_writer;
    import dijkstra_pkg::*;

    localparam int IW = DEFAULT_INDEX_WIDTH;
    localparam int AW = DEFAULT_MADDR_WIDTH;
    localparam int DW = DEFAULT_MDATA_WIDTH;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [IW-1:0] source, destination, number_of_nodes;
    logic [AW-1:0] out_base_address;
    logic [IW-1:0] prev_index, prev_value;
    logic          mem_write_enable;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_write_data;
    logic          mem_write_ready;
    logic          done, no_path;

    logic [IW-1:0] prev_tbl [0:255];
    assign prev_value = prev_tbl[prev_index];

    path_writer dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .source           (source),
        .destination      (destination),
        .number_of_nodes  (number_of_nodes),
        .out_base_address (out_base_address),
        .prev_index       (prev_index),
        .prev_value       (prev_value),
        .mem_write_enable (mem_write_enable),
        .mem_addr         (mem_addr),
        .mem_write_data   (mem_write_data),
        .mem_write_ready  (mem_write_ready),
        .done             (done),
        .no_path          (no_path)
    );

    always #5 clock = ~clock;

    // Write log: every accepted write, in order.
    logic          log_clr;
    int            nw;
    logic [AW-1:0] wa [0:15];
    logic [DW-1:0] wd [0:15];

    always @(posedge clock) begin
        if (log_clr) begin
            nw <= 0;
        end else if (mem_write_enable && mem_write_ready && !reset) begin
            if (nw < 16) begin
                wa[nw] <= mem_addr;
                wd[nw] <= mem_write_data;
            end
            nw <= nw + 1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_wr(input string tag, input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        check({tag, "_addr"}, 64'(wa[i]), 64'(a));
        check({tag, "_data"}, 64'(wd[i]), 64'(d));
    endtask

    task automatic clear_log;
        log_clr = 1'b1;
        @(negedge clock);
        log_clr = 1'b0;
    endtask

    // Returns at the sample point of cycle 1 after the start edge.
    task automatic start_walk(input logic [IW-1:0] s, input logic [IW-1:0] d,
                              input logic [IW-1:0] n, input logic [AW-1:0] b);
        source           = s;
        destination      = d;
        number_of_nodes  = n;
        out_base_address = b;
        start            = 1'b1;
        @(negedge clock);
        start            = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 300) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    int c;

    initial begin
        for (int i = 0; i < 256; i++) prev_tbl[i] = 8'hFF;
        reset = 1'b1; start = 1'b0; log_clr = 1'b1; mem_write_ready = 1'b1;
        source = '0; destination = '0; number_of_nodes = '0; out_base_address = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0; log_clr = 1'b0;

        // Reset state
        check("rst_we",    64'(mem_write_enable), 64'd0);
        check("rst_addr",  64'(mem_addr),         64'd0);
        check("rst_data",  64'(mem_write_data),   64'd0);
        check("rst_done",  64'(done),             64'd0);
        check("rst_nopath",64'(no_path),          64'd0);
        check("rst_pidx",  64'(prev_index),       64'd0);

        // 1: chain 3 -> 1 -> 0
        prev_tbl[3] = 8'd1; prev_tbl[1] = 8'd0;
        start_walk(8'd0, 8'd3, 8'd8, 16'h0100);
        check("s1_pidx", 64'(prev_index), 64'd3);
        wait_done(c);
        check("s1_cycles", 64'(c), 64'd7);
        check("s1_nopath", 64'(no_path), 64'd0);
        check("s1_nw", 64'(nw), 64'd4);
        check_wr("s1_w0", 0, 16'h0101, 32'd3);
        check_wr("s1_w1", 1, 16'h0102, 32'd1);
        check_wr("s1_w2", 2, 16'h0103, 32'd0);
        check_wr("s1_w3", 3, 16'h0100, 32'd3);

        // 2: source == destination, started from DONE
        clear_log;
        start_walk(8'd5, 8'd5, 8'd8, 16'h0100);
        check("s2_done_drop", 64'(done), 64'd0);
        wait_done(c);
        check("s2_cycles", 64'(c), 64'd3);
        check("s2_nw", 64'(nw), 64'd2);
        check_wr("s2_w0", 0, 16'h0101, 32'd5);
        check_wr("s2_w1", 1, 16'h0100, 32'd1);

        // 3: unreachable destination
        clear_log;
        start_walk(8'd0, 8'd4, 8'd8, 16'h0100);
        wait_done(c);
        check("s3_cycles", 64'(c), 64'd4);
        check("s3_nopath", 64'(no_path), 64'd1);
        check("s3_nw", 64'(nw), 64'd2);
        check_wr("s3_w0", 0, 16'h0101, 32'd4);
        check_wr("s3_w1", 1, 16'h0100, 32'd0);

        // 4: ready low for 3 cycles during the second node write
        clear_log;
        start_walk(8'd0, 8'd3, 8'd8, 16'h0100);
        @(negedge clock);
        mem_write_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("s4_hold_we",   64'(mem_write_enable), 64'd1);
            check("s4_hold_addr", 64'(mem_addr),         64'h0102);
            check("s4_hold_data", 64'(mem_write_data),   64'd1);
        end
        check("s4_nw_stall", 64'(nw), 64'd1);
        mem_write_ready = 1'b1;
        wait_done(c);
        check("s4_done", 64'(done), 64'd1);
        check("s4_nw", 64'(nw), 64'd4);
        check_wr("s4_w0", 0, 16'h0101, 32'd3);
        check_wr("s4_w1", 1, 16'h0102, 32'd1);
        check_wr("s4_w2", 2, 16'h0103, 32'd0);
        check_wr("s4_w3", 3, 16'h0100, 32'd3);

        // 5: cyclic table 2 <-> 3, guard of 4
        prev_tbl[2] = 8'd3; prev_tbl[3] = 8'd2;
        clear_log;
        start_walk(8'd0, 8'd2, 8'd4, 16'h0100);
        wait_done(c);
        check("s5_done", 64'(done), 64'd1);
        check("s5_nopath", 64'(no_path), 64'd1);
        check("s5_nw", 64'(nw), 64'd5);
        check_wr("s5_w0", 0, 16'h0101, 32'd2);
        check_wr("s5_w1", 1, 16'h0102, 32'd3);
        check_wr("s5_w2", 2, 16'h0103, 32'd2);
        check_wr("s5_w3", 3, 16'h0104, 32'd3);
        check_wr("s5_w4", 4, 16'h0100, 32'd0);

        // 6: reset during WRITE_NODE, then a clean walk
        prev_tbl[3] = 8'd1;
        mem_write_ready = 1'b0;
        start_walk(8'd0, 8'd3, 8'd8, 16'h0100);
        check("s6_we_pre", 64'(mem_write_enable), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        check("s6_we_rst",   64'(mem_write_enable), 64'd0);
        check("s6_addr_rst", 64'(mem_addr),         64'd0);
        check("s6_done_rst", 64'(done),             64'd0);
        reset = 1'b0;
        mem_write_ready = 1'b1;
        clear_log;
        start_walk(8'd0, 8'd3, 8'd8, 16'h0100);
        wait_done(c);
        check("s6_cycles", 64'(c), 64'd7);
        check("s6_done", 64'(done), 64'd1);
        check("s6_nopath", 64'(no_path), 64'd0);
        check("s6_nw", 64'(nw), 64'd4);
        check_wr("s6_w0", 0, 16'h0101, 32'd3);
        check_wr("s6_w3", 3, 16'h0100, 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/path_writer.md
Name: path_writer

Overview:
- Runs after the shortest-path search has filled the predecessor table. Walks the table from destination back to source.
- Writes each node index to memory through the write half of the shared memory interface, then writes the path length.
- Produces the output-memory image of the result: it is the writer counterpart to the edge cache's adjacency reader. Top level muxes its mem_addr with the edge cache's after the search asserts ready.

Parameters:
- MAX_NODES, `DEFAULT_MAX_NODES, predecessor table depth; bound on path length.
- INDEX_WIDTH, `DEFAULT_INDEX_WIDTH, node index width.
- MADDR_WIDTH, `DEFAULT_MADDR_WIDTH, memory address width.
- MDATA_WIDTH, `DEFAULT_MDATA_WIDTH, memory data width; must be >= INDEX_WIDTH.

Ports:
- clock  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  pulse; begin a walk (honoured in IDLE or DONE only).
- source  input  INDEX_WIDTH  walk terminator; latched on start.
- destination  input  INDEX_WIDTH  walk origin; latched on start.
- number_of_nodes  input  INDEX_WIDTH  loop guard; latched on start.
- out_base_address  input  MADDR_WIDTH  output region base; latched on start.
- prev_index  output  INDEX_WIDTH  predecessor table read address; always equals cur.
- prev_value  input  INDEX_WIDTH  predecessor of prev_index; combinational, same cycle.
- mem_write_enable  output  1  write request.
- mem_addr  output  MADDR_WIDTH  write address.
- mem_write_data  output  MDATA_WIDTH  write data.
- mem_write_ready  input  1  write accepted this cycle when high together with enable.
- done  output  1  walk finished; held until next start or reset.
- no_path  output  1  valid with done; destination unreachable or chain malformed.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; cur, count, done, no_path, mem_write_enable, mem_addr and mem_write_data all 0. Reset mid-write drops mem_write_enable at that edge and abandons the walk; partial memory contents are undefined.
- Handshake: in a write state, enable/addr/data stay stable until a cycle with mem_write_ready=1. The write completes in that cycle and the FSM advances at its edge. There is no combinational path from mem_write_ready to any output.
- IDLE: on start, latch inputs; cur<=destination; count<=0; no_path<=0; done<=0; go to WRITE_NODE.
- WRITE_NODE: mem_addr=base+1+count, with address arithmetic modulo 2^MADDR_WIDTH (wraps). mem_write_data=cur zero-extended. On accept: count<=count+1; if cur==source go to WRITE_LEN, else go to STEP.
- STEP (no memory request):
  - If prev_value==`NO_PREVIOUS_NODE, or count>=number_of_nodes (cycle guard): no_path<=1, go to WRITE_LEN.
  - Otherwise cur<=prev_value, go to WRITE_NODE.
- WRITE_LEN: mem_addr=base. mem_write_data = no_path ? 0 : count, zero-extended. On accept go to DONE.
- DONE: done=1; no_path is held. A start here behaves as in IDLE (done drops the next cycle).
- start is ignored in WRITE_NODE, STEP and WRITE_LEN.
- Path order in memory: destination first at base+1, source last at base+L.
- source==destination: one entry, length 1.
- Latency, with mem_write_ready tied high: for a path of L nodes, the FSM spends 2L cycles in states, and done is high in cycle 2L+1 after the start edge.
- Unreachable destination: base+1 still holds destination; the length word at base is 0.
- count width is INDEX_WIDTH+1, so a path of exactly MAX_NODES nodes does not overflow.

Decomposition:
- Shared package dijkstra_pkg:
  - path_writer_state_t enum {IDLE, WRITE_NODE, STEP, WRITE_LEN, DONE}.
  - Re-exports of `NO_PREVIOUS_NODE and the DEFAULT_* widths from constants.v.
- No sub-module is needed; the block is a single FSM with a datapath.
- The top level owns the prev_vector read port and the memory-interface mux.

Test Plan:
- Chain prev[3]=1, prev[1]=0, source=0, dest=3, base=0x100, ready high -> writes 0x101=3, 0x102=1, 0x103=0, 0x100=3; done at cycle 7 after start; no_path=0.
- source=dest=5 -> single write 0x101=5, then 0x100=1; done at cycle 3.
- prev[4]=NO_PREVIOUS_NODE, dest=4, source=0 -> 0x101=4, 0x100=0; no_path=1.
- mem_write_ready low for 3 cycles during the second node write -> addr/data held stable, no duplicate write; final memory matches the first scenario.
- Cyclic table prev[2]=3, prev[3]=2, number_of_nodes=4, source=0 -> terminates after 4 node writes; length 0; no_path=1.
- Reset asserted while in WRITE_NODE, then a new start -> enable 0 at the reset edge; second walk completes correctly with done and no_path cleared.
